ex_stage_pipe: RTL and testbench

EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

---
 rtl/ex_stage_pipe.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_pipe.sv
// Execute stage: single-cycle ALU ops plus a multi-cycle shift-add MUL.
// Ports:
//   clk, rst(async, active-low)
//   in_valid, stall, flush        pipeline handshake and kill
//   alu_funct, alu_src, reg_dest  ALU op, op2 select, dest select
//   data_rs/rt, imm, address_*    operands and register addresses
//   next_pc                       branch target base
//   *_enable, is_branch, wb_res_mux  control pass-through
//   busy                          MUL in progress; upstream holds
//   out_*                         registered results and controls
module ex_stage_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int PC_WIDTH       = 32,
  parameter int LINK_REG       = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [5:0]                alu_funct,
  input  logic                      alu_src,
  input  logic [1:0]                reg_dest,
  input  logic [DATA_WIDTH-1:0]     data_rs,
  input  logic [DATA_WIDTH-1:0]     data_rt,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic [REG_ADDR_WIDTH-1:0] address_rs,
  input  logic [REG_ADDR_WIDTH-1:0] address_rt,
  input  logic [REG_ADDR_WIDTH-1:0] address_rd,
  input  logic [PC_WIDTH-1:0]       next_pc,
  input  logic                      mem_write_enable,
  input  logic                      reg_write_enable,
  input  logic                      is_branch,
  input  logic                      fl_write_enable,
  input  logic [1:0]                wb_res_mux,
  output logic                      busy,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_alu_data,
  output logic [3:0]                out_flags,
  output logic [PC_WIDTH-1:0]       out_target,
  output logic [DATA_WIDTH-1:0]     out_data_rt,
  output logic [REG_ADDR_WIDTH-1:0] out_dest,
  output logic [REG_ADDR_WIDTH-1:0] out_address_rs,
  output logic                      out_mem_write_enable,
  output logic                      out_reg_write_enable,
  output logic                      out_is_branch,
  output logic                      out_fl_write_enable,
  output logic [1:0]                out_wb_res_mux
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = SHW + 1;
  localparam int DW  = DATA_WIDTH;
  localparam int AW  = REG_ADDR_WIDTH;

  localparam logic [5:0] F_ADD = 6'h00;
  localparam logic [5:0] F_SUB = 6'h01;
  localparam logic [5:0] F_AND = 6'h02;
  localparam logic [5:0] F_OR  = 6'h03;
  localparam logic [5:0] F_XOR = 6'h04;
  localparam logic [5:0] F_SLT = 6'h05;
  localparam logic [5:0] F_SLL = 6'h06;
  localparam logic [5:0] F_SRL = 6'h07;
  localparam logic [5:0] F_MUL = 6'h08;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0]  w_op2;
  logic [SHW-1:0] w_shamt;
  logic [DW:0]    w_sum;
  logic [DW:0]    w_dif;
  logic [DW-1:0]  w_res;
  logic           w_c;
  logic           w_v;
  logic           w_known;
  logic [3:0]     w_flags;
  logic [PC_WIDTH-1:0] w_target;
  logic [AW-1:0]  w_dest;
  logic           w_is_mul;

  logic [DW-1:0]  r_mcand;
  logic [DW-1:0]  r_mplier;
  logic [DW-1:0]  r_acc;
  logic [CW-1:0]  r_cnt;
  logic [DW-1:0]  w_acc_nx;
  logic           w_last;

  logic [DW-1:0]       r_p_data_rt;
  logic [AW-1:0]       r_p_dest;
  logic [AW-1:0]       r_p_rs;
  logic [PC_WIDTH-1:0] r_p_target;
  logic                r_p_mwe;
  logic                r_p_rwe;
  logic                r_p_br;
  logic                r_p_fwe;
  logic [1:0]          r_p_wb;

  logic                r_valid;
  logic [DW-1:0]       r_alu;
  logic [3:0]          r_flags;
  logic [PC_WIDTH-1:0] r_target;
  logic [DW-1:0]       r_data_rt;
  logic [AW-1:0]       r_dest;
  logic [AW-1:0]       r_rs;
  logic                r_mwe;
  logic                r_rwe;
  logic                r_br;
  logic                r_fwe;
  logic [1:0]          r_wb;

  // Single-cycle ALU
  always_comb begin
    w_op2   = alu_src ? imm : data_rt;
    w_shamt = w_op2[SHW-1:0];
    w_sum   = {1'b0, data_rs} + {1'b0, w_op2};
    w_dif   = {1'b0, data_rs} + {1'b0, ~w_op2}
            + (DW+1)'(1);
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_known = 1'b1;
    case (alu_funct)
      F_ADD: begin
        w_res = w_sum[DW-1:0];
        w_c   = w_sum[DW];
        w_v   = (data_rs[DW-1] == w_op2[DW-1])
             && (w_res[DW-1] != data_rs[DW-1]);
      end
      F_SUB: begin
        w_res = w_dif[DW-1:0];
        w_c   = w_dif[DW];
        w_v   = (data_rs[DW-1] != w_op2[DW-1])
             && (w_res[DW-1] != data_rs[DW-1]);
      end
      F_AND: w_res = data_rs & w_op2;
      F_OR:  w_res = data_rs | w_op2;
      F_XOR: w_res = data_rs ^ w_op2;
      F_SLT: w_res = {{(DW-1){1'b0}},
                      $signed(data_rs) < $signed(w_op2)};
      F_SLL: w_res = data_rs << w_shamt;
      F_SRL: w_res = data_rs >> w_shamt;
      F_MUL: w_res = '0;
      default: w_known = 1'b0;
    endcase
    // Unknown opcodes report all-zero flags, Z included
    w_flags = w_known
            ? {w_res[DW-1], w_res == '0, w_c, w_v}
            : 4'b0000;
  end

  assign w_target = next_pc + PC_WIDTH'(imm);
  assign w_is_mul = (alu_funct == F_MUL);

  always_comb begin
    case (reg_dest)
      2'd0:    w_dest = address_rt;
      2'd1:    w_dest = address_rd;
      default: w_dest = AW'(LINK_REG);
    endcase
  end

  // Shift-add step; final step folds in the last partial product
  assign w_acc_nx = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last   = (r_cnt == CW'(DW - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else if (!stall) begin
      case (r_state)
        S_IDLE:  if (in_valid && w_is_mul)
                   w_next = S_MUL;
        S_MUL:   if (w_last) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == S_MUL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_p_data_rt <= '0;
      r_p_dest    <= '0;
      r_p_rs      <= '0;
      r_p_target  <= '0;
      r_p_mwe     <= 1'b0;
      r_p_rwe     <= 1'b0;
      r_p_br      <= 1'b0;
      r_p_fwe     <= 1'b0;
      r_p_wb      <= '0;
      r_valid     <= 1'b0;
      r_alu       <= '0;
      r_flags     <= '0;
      r_target    <= '0;
      r_data_rt   <= '0;
      r_dest      <= '0;
      r_rs        <= '0;
      r_mwe       <= 1'b0;
      r_rwe       <= 1'b0;
      r_br        <= 1'b0;
      r_fwe       <= 1'b0;
      r_wb        <= '0;
    end else if (flush) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_mwe   <= 1'b0;
      r_rwe   <= 1'b0;
      r_br    <= 1'b0;
      r_fwe   <= 1'b0;
    end else if (!stall) begin
      if (r_state == S_IDLE) begin
        if (in_valid && w_is_mul) begin
          r_mcand     <= data_rs;
          r_mplier    <= w_op2;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_p_data_rt <= data_rt;
          r_p_dest    <= w_dest;
          r_p_rs      <= address_rs;
          r_p_target  <= w_target;
          r_p_mwe     <= mem_write_enable;
          r_p_rwe     <= reg_write_enable;
          r_p_br      <= is_branch;
          r_p_fwe     <= fl_write_enable;
          r_p_wb      <= wb_res_mux;
          r_valid     <= 1'b0;
          r_mwe       <= 1'b0;
          r_rwe       <= 1'b0;
          r_br        <= 1'b0;
          r_fwe       <= 1'b0;
        end else if (in_valid) begin
          r_valid   <= 1'b1;
          r_alu     <= w_res;
          r_flags   <= w_flags;
          r_target  <= w_target;
          r_data_rt <= data_rt;
          r_dest    <= w_dest;
          r_rs      <= address_rs;
          r_mwe     <= mem_write_enable;
          r_rwe     <= reg_write_enable;
          r_br      <= is_branch;
          r_fwe     <= fl_write_enable;
          r_wb      <= wb_res_mux;
        end else begin
          r_valid <= 1'b0;
          r_mwe   <= 1'b0;
          r_rwe   <= 1'b0;
          r_br    <= 1'b0;
          r_fwe   <= 1'b0;
        end
      end else begin
        r_acc    <= w_acc_nx;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          r_cnt     <= '0;
          r_valid   <= 1'b1;
          r_alu     <= w_acc_nx;
          r_flags   <= {w_acc_nx[DW-1],
                        w_acc_nx == '0, 2'b00};
          r_target  <= r_p_target;
          r_data_rt <= r_p_data_rt;
          r_dest    <= r_p_dest;
          r_rs      <= r_p_rs;
          r_mwe     <= r_p_mwe;
          r_rwe     <= r_p_rwe;
          r_br      <= r_p_br;
          r_fwe     <= r_p_fwe;
          r_wb      <= r_p_wb;
        end
      end
    end
  end

  assign out_valid            = r_valid;
  assign out_alu_data         = r_alu;
  assign out_flags            = r_flags;
  assign out_target           = r_target;
  assign out_data_rt          = r_data_rt;
  assign out_dest             = r_dest;
  assign out_address_rs       = r_rs;
  assign out_mem_write_enable = r_mwe;
  assign out_reg_write_enable = r_rwe;
  assign out_is_branch        = r_br;
  assign out_fl_write_enable  = r_fwe;
  assign out_wb_res_mux       = r_wb;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Testbench for ex_stage_pipe: ALU vector table plus
// hand-written MUL, stall, flush and reset sequences.
module tb_ex_stage_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid, stall, flush;
  logic [5:0]  alu_funct;
  logic        alu_src;
  logic [1:0]  reg_dest;
  logic [31:0] data_rs, data_rt, imm;
  logic [3:0]  address_rs, address_rt, address_rd;
  logic [31:0] next_pc;
  logic        mem_write_enable, reg_write_enable;
  logic        is_branch, fl_write_enable;
  logic [1:0]  wb_res_mux;
  logic        busy, out_valid;
  logic [31:0] out_alu_data;
  logic [3:0]  out_flags;
  logic [31:0] out_target, out_data_rt;
  logic [3:0]  out_dest, out_address_rs;
  logic        out_mem_write_enable, out_reg_write_enable;
  logic        out_is_branch, out_fl_write_enable;
  logic [1:0]  out_wb_res_mux;

  int errors = 0;
  int checks = 0;

  ex_stage_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_funct(alu_funct), .alu_src(alu_src),
    .reg_dest(reg_dest),
    .data_rs(data_rs), .data_rt(data_rt), .imm(imm),
    .address_rs(address_rs), .address_rt(address_rt),
    .address_rd(address_rd), .next_pc(next_pc),
    .mem_write_enable(mem_write_enable),
    .reg_write_enable(reg_write_enable),
    .is_branch(is_branch),
    .fl_write_enable(fl_write_enable),
    .wb_res_mux(wb_res_mux),
    .busy(busy), .out_valid(out_valid),
    .out_alu_data(out_alu_data), .out_flags(out_flags),
    .out_target(out_target), .out_data_rt(out_data_rt),
    .out_dest(out_dest), .out_address_rs(out_address_rs),
    .out_mem_write_enable(out_mem_write_enable),
    .out_reg_write_enable(out_reg_write_enable),
    .out_is_branch(out_is_branch),
    .out_fl_write_enable(out_fl_write_enable),
    .out_wb_res_mux(out_wb_res_mux)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic        src;
    logic [1:0]  sel;
    logic [31:0] rs, rt, im, pc;
    logic [3:0]  ard;
    logic [31:0] e_alu;
    logic [3:0]  e_fl;
    logic [31:0] e_tg;
    logic [3:0]  e_dst;
  } vec_t;

  vec_t v[14];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive_op(input logic [5:0] f,
                          input logic [31:0] a,
                          input logic [31:0] b);
    in_valid = 1'b1;
    alu_funct = f;
    alu_src = 1'b0;
    reg_dest = 2'd1;
    data_rs = a;
    data_rt = b;
    imm = 32'h4;
    address_rd = 4'hC;
    next_pc = 32'h200;
    reg_write_enable = 1'b1;
    mem_write_enable = 1'b0;
    is_branch = 1'b0;
    fl_write_enable = 1'b1;
    wb_res_mux = 2'd2;
  endtask

  // Accept a MUL, change inputs (must be ignored), then
  // count edges to completion with optional stall window.
  task automatic run_mul(input logic [31:0] a,
                         input logic [31:0] b,
                         input int st, input int sl,
                         input int exp_edges,
                         input logic [31:0] exp_res,
                         input logic [3:0] exp_fl);
    int edges;
    logic drop;
    @(negedge clk);
    drive_op(6'h08, a, b);
    @(posedge clk); #1;
    chk("mul_accept_busy", busy, 1);
    chk("mul_accept_valid", out_valid, 0);
    edges = 1;
    drop = 1'b0;
    while (out_valid !== 1'b1 && edges < 100) begin
      @(negedge clk);
      drive_op(6'h00, 32'd1, 32'd1);
      address_rd = 4'h3;
      reg_write_enable = 1'b0;
      stall = (edges >= st && edges < st + sl);
      @(posedge clk); #1;
      edges++;
      if (out_valid !== 1'b1 && busy !== 1'b1)
        drop = 1'b1;
    end
    @(negedge clk);
    stall = 1'b0;
    in_valid = 1'b0;
    chk("mul_latency", 64'(edges), 64'(exp_edges));
    chk("mul_busy_held", drop, 0);
    chk("mul_result", out_alu_data, exp_res);
    chk("mul_flags", out_flags, exp_fl);
    chk("mul_ctrl", {busy, out_dest,
                     out_reg_write_enable, out_wb_res_mux,
                     out_target},
        {1'b0, 4'hC, 1'b1, 2'd2, 32'h204});
  endtask

  task automatic mul_steps(input logic [31:0] a,
                           input int n);
    @(negedge clk);
    drive_op(6'h08, a, 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
    chk("mul_midway_busy", busy, 1);
  endtask

  initial begin
    v[0]  = '{6'h00, 1'b0, 2'd1, 32'd5, 32'd7, 32'h10,
              32'h100, 4'd9, 32'd12, 4'b0000, 32'h110,
              4'd9};
    v[1]  = '{6'h00, 1'b1, 2'd0, 32'h7FFFFFFF, 32'd0,
              32'd1, 32'd0, 4'd0, 32'h80000000, 4'b1001,
              32'd1, 4'd6};
    v[2]  = '{6'h01, 1'b0, 2'd1, 32'd3, 32'd3, 32'd0,
              32'h20, 4'd4, 32'd0, 4'b0110, 32'h20, 4'd4};
    v[3]  = '{6'h01, 1'b0, 2'd1, 32'd3, 32'd5, 32'd0,
              32'd0, 4'd4, 32'hFFFFFFFE, 4'b1000, 32'd0,
              4'd4};
    v[4]  = '{6'h02, 1'b0, 2'd1, 32'hF0F0, 32'h0FF0,
              32'd4, 32'd8, 4'd1, 32'h00F0, 4'b0000,
              32'hC, 4'd1};
    v[5]  = '{6'h03, 1'b0, 2'd1, 32'hF000, 32'h000F,
              32'd0, 32'd0, 4'd2, 32'hF00F, 4'b0000,
              32'd0, 4'd2};
    v[6]  = '{6'h04, 1'b1, 2'd1, 32'hFF, 32'd0, 32'h0F,
              32'h10, 4'd3, 32'hF0, 4'b0000, 32'h1F, 4'd3};
    v[7]  = '{6'h05, 1'b0, 2'd1, 32'hFFFFFFFF, 32'd1,
              32'd0, 32'd0, 4'd5, 32'd1, 4'b0000, 32'd0,
              4'd5};
    v[8]  = '{6'h05, 1'b0, 2'd3, 32'd5, 32'd3, 32'd0,
              32'd0, 4'd5, 32'd0, 4'b0100, 32'd0, 4'd15};
    v[9]  = '{6'h06, 1'b1, 2'd1, 32'd1, 32'd0, 32'd31,
              32'd0, 4'd7, 32'h80000000, 4'b1000,
              32'd31, 4'd7};
    v[10] = '{6'h07, 1'b0, 2'd1, 32'h80000000, 32'h24,
              32'd0, 32'd0, 4'd8, 32'h08000000, 4'b0000,
              32'd0, 4'd8};
    v[11] = '{6'h3F, 1'b0, 2'd1, 32'd5, 32'd7, 32'd0,
              32'h40, 4'd9, 32'd0, 4'b0000, 32'h40, 4'd9};
    v[12] = '{6'h00, 1'b0, 2'd1, 32'hFFFFFFFF, 32'd1,
              32'd0, 32'd0, 4'd10, 32'd0, 4'b0110, 32'd0,
              4'd10};
    v[13] = '{6'h02, 1'b1, 2'd2, 32'hFF, 32'd0, 32'd8,
              32'hFFFFFFFC, 4'd3, 32'd8, 4'b0000, 32'd4,
              4'd15};

    rst = 1'b0;
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    alu_funct = '0; alu_src = 1'b0; reg_dest = '0;
    data_rs = '0; data_rt = '0; imm = '0;
    address_rs = 4'hA; address_rt = 4'h6;
    address_rd = '0; next_pc = '0;
    mem_write_enable = 1'b0; reg_write_enable = 1'b0;
    is_branch = 1'b0; fl_write_enable = 1'b0;
    wb_res_mux = '0;
    #1;
    chk("reset_state", {busy, out_valid, out_alu_data,
                        out_flags, out_dest},
        '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      alu_funct = v[i].f;
      alu_src = v[i].src;
      reg_dest = v[i].sel;
      data_rs = v[i].rs;
      data_rt = v[i].rt;
      imm = v[i].im;
      next_pc = v[i].pc;
      address_rd = v[i].ard;
      mem_write_enable = i[0];
      reg_write_enable = 1'b1;
      is_branch = i[1];
      fl_write_enable = i[2];
      wb_res_mux = i[1:0];
      @(posedge clk); #1;
      chk($sformatf("v%0d_alu", i), out_alu_data,
          v[i].e_alu);
      chk($sformatf("v%0d_flags", i), out_flags,
          v[i].e_fl);
      chk($sformatf("v%0d_target", i), out_target,
          v[i].e_tg);
      chk($sformatf("v%0d_dest", i), out_dest,
          v[i].e_dst);
      chk($sformatf("v%0d_ctrl", i),
          {out_valid, out_data_rt, out_address_rs,
           out_mem_write_enable, out_reg_write_enable,
           out_is_branch, out_fl_write_enable,
           out_wb_res_mux},
          {1'b1, v[i].rt, 4'hA, i[0], 1'b1, i[1], i[2],
           i[1:0]});
    end

    // Stall freezes outputs of the last vector
    @(negedge clk);
    drive_op(6'h00, 32'd5, 32'd7);
    stall = 1'b1;
    @(posedge clk); #1;
    chk("stall_hold", {out_valid, out_alu_data,
                       out_dest},
        {1'b1, 32'd8, 4'd15});

    // Bubble
    @(negedge clk);
    stall = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bubble", {out_valid, out_mem_write_enable,
                   out_reg_write_enable, out_is_branch,
                   out_fl_write_enable}, '0);

    // Flush beats stall on a fresh valid result
    @(negedge clk);
    drive_op(6'h00, 32'd2, 32'd2);
    @(posedge clk); #1;
    chk("pre_flush_valid", {out_valid, out_alu_data},
        {1'b1, 32'd4});
    @(negedge clk);
    flush = 1'b1;
    stall = 1'b1;
    @(posedge clk); #1;
    chk("flush_idle", {out_valid, out_reg_write_enable,
                       out_fl_write_enable}, '0);
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    in_valid = 1'b0;

    run_mul(32'd6, 32'd7, 0, 0, 33, 32'd42, 4'b0000);
    run_mul(32'h10001, 32'h10001, 10, 5, 38,
            32'h00020001, 4'b0000);
    run_mul(32'hFFFFFFFF, 32'd2, 0, 0, 33,
            32'hFFFFFFFE, 4'b1000);

    // Flush aborts MUL at step 10
    mul_steps(32'd9, 10);
    @(negedge clk);
    flush = 1'b1;
    stall = 1'b1;
    @(posedge clk); #1;
    chk("mul_flush", {busy, out_valid,
                      out_reg_write_enable}, '0);
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    drive_op(6'h00, 32'd2, 32'd2);
    @(posedge clk); #1;
    chk("post_flush_add", {busy, out_valid, out_alu_data},
        {1'b0, 1'b1, 32'd4});

    // Async reset mid-MUL, away from any clock edge
    mul_steps(32'd9, 10);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", {busy, out_valid, out_alu_data,
                        out_target, out_dest,
                        out_reg_write_enable,
                        out_wb_res_mux}, '0);
    @(negedge clk);
    rst = 1'b1;
    drive_op(6'h00, 32'd5, 32'd7);
    @(posedge clk); #1;
    chk("first_capture", {busy, out_valid, out_alu_data},
        {1'b0, 1'b1, 32'd12});

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
